avr_prefetch: RTL
=================

AVR_PREFETCH -- requirements
Module: avr_prefetch

Interface
REQ-001 Parameter PC_W, default 16, program-word address width.
REQ-002 Parameter DEPTH, default 4, prefetch buffer entries in 16-bit words; power of 2, at least 2.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset; asynchronous assert, active-low.
REQ-005 p_addr  out  PC_W  program-memory word address.
REQ-006 p_req  out  1  fetch request.
REQ-007 p_ack  in  1  memory accepts request; p_rdata valid in the same cycle.
REQ-008 p_rdata  in  16  fetched program word.
REQ-009 redirect  in  1  branch/jump/reset-vector flush strobe.
REQ-010 redirect_pc  in  PC_W  new fetch address, sampled when redirect=1.
REQ-011 instr  out  32  instruction: [15:0] first word, [31:16] second word (0 for one-word opcodes).
REQ-012 instr_pc  out  PC_W  address of first word of instr.
REQ-013 instr_2w  out  1  instr is a two-word opcode.
REQ-014 instr_valid  out  1  instr/instr_pc/instr_2w valid.
REQ-015 instr_ready  in  1  core consumes instr when instr_valid && instr_ready.

Function
REQ-016 Buffer SHALL be a circular FIFO of DEPTH entries {word, pc}; pointers wrap modulo DEPTH.
REQ-017 Fetch FSM SHALL have states IDLE, WAIT, WAIT_DROP.
REQ-018 IDLE -> WAIT, asserting p_req with p_addr=fetch_pc, when occupancy < DEPTH; else stay IDLE with p_req=0.
REQ-019 In WAIT/WAIT_DROP, p_req and p_addr SHALL hold stable until p_ack=1; at most one request outstanding.
REQ-020 p_ack=1 in the same cycle p_req rises (zero-wait memory) SHALL be legal; word is written at that edge.
REQ-021 On p_ack in WAIT without redirect: push {p_rdata, fetch_pc}, fetch_pc += 1 modulo 2^PC_W, then issue next request back-to-back if space remains after the push and pop of that cycle, else IDLE.
REQ-022 On p_ack in WAIT_DROP: discard p_rdata, no push; next request from the redirected fetch_pc.
REQ-023 redirect=1: flush FIFO (occupancy 0), fetch_pc <= redirect_pc; state WAIT -> WAIT_DROP unless p_ack is also 1 that cycle (word dropped, new request next cycle); IDLE -> IDLE.
REQ-024 redirect and a pop in the same cycle: redirect wins, pop has no effect on the flushed buffer; instr_valid=0 in the following cycle.
REQ-025 Head word is two-word iff (w & 0xFE0F) is 0x9000 or 0x9200 (LDS/STS), or (w & 0xFE0E) is 0x940C or 0x940E (JMP/CALL).
REQ-026 instr_valid=1 iff occupancy>=1 and head is one-word, or occupancy>=2 and head is two-word.
REQ-027 Handshake pops 1 word (one-word) or 2 words (two-word); push and pop in the same cycle SHALL both take effect.
REQ-028 Outputs SHALL be combinational from FIFO head; minimum latency p_ack edge -> instr_valid is one cycle.
REQ-029 Address wrap: after fetching word 2^PC_W-1, next p_addr SHALL be 0; a two-word opcode straddling the wrap is valid.

Reset
REQ-030 While RST=0: state IDLE, fetch_pc=0, occupancy 0, p_req=0, p_addr=0, instr_valid=0, instr=0, instr_pc=0, instr_2w=0.
REQ-031 Reset asserted mid-request SHALL drop the request immediately; memory side tolerates p_req falling without p_ack.
REQ-032 First cycle after RST release: p_req=1, p_addr=0.

Structure
REQ-033 Shared package avr_pkg SHALL hold FSM state enum and the four two-word opcode mask/value constants (also for the decoder).
REQ-034 FIFO SHALL be sub-module avr_prefetch_fifo (params DEPTH, width 16+PC_W; push, pop1, pop2, flush, count).

Verification
REQ-035 Reset release, p_ack tied 1, memory holds 0x0000 everywhere, instr_ready=1 -> instr_valid from cycle 2, instr_pc 0,1,2,... one per cycle.
REQ-036 Words 0x940C,0x0100 at addr 0-1 -> one transfer: instr=0x0100940C, instr_2w=1, instr_pc=0; next instr_pc=2.
REQ-037 instr_ready=0, zero-wait memory -> exactly DEPTH (4) acks then p_req=0; occupancy stays 4.
REQ-038 p_ack delayed 3 cycles, redirect(redirect_pc=0x0040) during WAIT -> p_addr unchanged until ack, acked word discarded, next p_addr=0x0040, first instr_pc=0x0040.
REQ-039 PC_W=8, redirect_pc=0xFF, words 0x9000@0xFF, 0x1234@0x00 -> instr=0x12349000, instr_pc=0xFF, instr_2w=1; p_addr sequence 0xFF,0x00,0x01.
REQ-040 RST asserted with p_req=1 and buffer holding 3 words -> same cycle p_req=0, instr_valid=0; after release p_addr=0.

Source files
------------

// File: rtl/avr_pkg.sv
// Shared definitions for the AVR instruction prefetch path: fetch FSM states
// and the opcode patterns that mark a two-word instruction.
package avr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT      = 2'd1,
    ST_WAIT_DROP = 2'd2
  } fetch_state_t;

  localparam logic [15:0] LDS_STS_MASK  = 16'hFE0F;
  localparam logic [15:0] LDS_VAL       = 16'h9000;
  localparam logic [15:0] STS_VAL       = 16'h9200;
  localparam logic [15:0] JMP_CALL_MASK = 16'hFE0E;
  localparam logic [15:0] JMP_VAL       = 16'h940C;
  localparam logic [15:0] CALL_VAL      = 16'h940E;

  // LDS/STS carry a 16-bit data address, JMP/CALL a 22-bit program address.
  function automatic logic is_two_word(input logic [15:0] w);
    logic lds_sts;
    logic jmp_call;
    lds_sts  = ((w & LDS_STS_MASK) == LDS_VAL) || ((w & LDS_STS_MASK) == STS_VAL);
    jmp_call = ((w & JMP_CALL_MASK) == JMP_VAL) || ((w & JMP_CALL_MASK) == CALL_VAL);
    return lds_sts || jmp_call;
  endfunction

endpackage

// File: rtl/avr_prefetch_fifo.sv
// Circular prefetch buffer of {pc, word} entries; can retire one or two words
// per cycle alongside a push, and exposes the head plus the following word.
module avr_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop1,
  input  logic                    pop2,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count,
  output logic [WIDTH-1:0]        head,
  output logic [15:0]             next_word
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    pop_cnt;

  always_comb begin
    pop_cnt = '0;
    if (pop2) begin
      pop_cnt = CW'(2);
    end else if (pop1) begin
      pop_cnt = CW'(1);
    end
  end

  assign rd_next   = rd_ptr + AW'(1);
  assign head      = mem[rd_ptr];
  assign next_word = mem[rd_next][15:0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      // Pointer width equals log2(DEPTH), so the truncated add wraps modulo DEPTH.
      rd_ptr <= rd_ptr + pop_cnt[AW-1:0];
      count  <= count + CW'(push) - pop_cnt;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/avr_prefetch.sv
// AVR program-memory prefetcher: keeps a small word buffer filled ahead of the
// core and presents whole one- or two-word instructions from its head.
module avr_prefetch
  import avr_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [PC_W-1:0] p_addr,
  output logic            p_req,
  input  logic            p_ack,
  input  logic [15:0]     p_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_2w,
  output logic            instr_valid,
  input  logic            instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 16 + PC_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t    state;
  logic [PC_W-1:0] fetch_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   pop_cnt;
  logic [EW-1:0]   head;
  logic [15:0]     head_word;
  logic [15:0]     next_word;
  logic            head_2w;
  logic            avail;
  logic            take;
  logic            pop1;
  logic            pop2;
  logic            push;
  logic            room_idle;
  logic            room_after_push;

  assign head_word = head[15:0];
  assign head_2w   = is_two_word(head_word);
  assign avail     = head_2w ? (count >= CW'(2)) : (count != '0);

  // A redirect flushes the buffer, so a simultaneous handshake must not pop.
  assign take    = avail && instr_ready && !redirect;
  assign pop1    = take && !head_2w;
  assign pop2    = take && head_2w;
  assign pop_cnt = pop2 ? CW'(2) : (pop1 ? CW'(1) : '0);
  assign push    = (state == ST_WAIT) && p_ack && !redirect;

  assign room_idle       = (count - pop_cnt) < FULL;
  assign room_after_push = (count + CW'(1) - pop_cnt) < FULL;

  avr_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .wdata     ({fetch_pc, p_rdata}),
    .pop1      (pop1),
    .pop2      (pop2),
    .flush     (redirect),
    .count     (count),
    .head      (head),
    .next_word (next_word)
  );

  always_comb begin
    instr_valid = avail;
    instr       = '0;
    instr_pc    = '0;
    instr_2w    = 1'b0;
    if (avail) begin
      instr    = {(head_2w ? next_word : 16'h0000), head_word};
      instr_pc = head[EW-1:16];
      instr_2w = head_2w;
    end
  end

  // p_addr tracks the outstanding request; fetch_pc may already point past a
  // redirect while a to-be-dropped request is still waiting for its ack.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      fetch_pc <= '0;
      p_addr   <= '0;
      p_req    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (room_idle) begin
            state  <= ST_WAIT;
            p_req  <= 1'b1;
            p_addr <= fetch_pc;
          end
        end
        ST_WAIT: begin
          if (p_ack) begin
            if (redirect) begin
              fetch_pc <= redirect_pc;
              p_addr   <= redirect_pc;
            end else begin
              fetch_pc <= fetch_pc + PC_W'(1);
              if (room_after_push) begin
                p_addr <= fetch_pc + PC_W'(1);
              end else begin
                state <= ST_IDLE;
                p_req <= 1'b0;
              end
            end
          end else if (redirect) begin
            fetch_pc <= redirect_pc;
            state    <= ST_WAIT_DROP;
          end
        end
        ST_WAIT_DROP: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end
          if (p_ack) begin
            state  <= ST_WAIT;
            p_addr <= redirect ? redirect_pc : fetch_pc;
          end
        end
        default: begin
          state <= ST_IDLE;
          p_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
